// File: rtl/multiplicador_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier.
// Contents:
//   LARGURA_PADRAO    default operand width (the Adder instance is 16 bits)
//   LARGURA_PRODUTO   product width for the default operand width
//   estado_t          controller state encoding (IDLE, CALC, DONE)
//   largura_contador  width of the iteration counter for a given operand width
package multiplicador_pkg;

  localparam int unsigned LARGURA_PADRAO  = 16;
  localparam int unsigned LARGURA_PRODUTO = 2 * LARGURA_PADRAO;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } estado_t;

  // The counter runs 0..largura-1; keep it at least one bit wide.
  function automatic int unsigned largura_contador(input int unsigned largura);
    return (largura > 1) ? $clog2(largura) : 1;
  endfunction

endpackage

// File: rtl/shift_add_multiplier_if.sv
// Operand/result bundle of the shift-and-add multiplier.
// Signals:
//   Start          request, sampled by the multiplier only while idle
//   Multiplicando  operand M, captured when Start is accepted
//   Multiplicador  operand Q, captured when Start is accepted
//   Produto        registered 2*LARGURA-bit product, holds the last result
//   Pronto         one-cycle strobe, Produto has just been updated
//   Ocupado        high while an operation is running or completing
// Modports:
//   master  requester side (drives Start and operands)
//   slave   multiplier side (drives Produto, Pronto, Ocupado)
interface shift_add_multiplier_if
  import multiplicador_pkg::*;
#(
  parameter int unsigned LARGURA = LARGURA_PADRAO
) ();

  logic                   Start;
  logic [LARGURA-1:0]     Multiplicando;
  logic [LARGURA-1:0]     Multiplicador;
  logic [2*LARGURA-1:0]   Produto;
  logic                   Pronto;
  logic                   Ocupado;

  modport master (
    output Start,
    output Multiplicando,
    output Multiplicador,
    input  Produto,
    input  Pronto,
    input  Ocupado
  );

  modport slave (
    input  Start,
    input  Multiplicando,
    input  Multiplicador,
    output Produto,
    output Pronto,
    output Ocupado
  );

endinterface

// File: rtl/Adder.sv
// 16-bit combinational adder used by the multiplier datapath.
// Ports:
//   OperandoA  16-bit addend
//   OperandoB  16-bit addend
//   Soma       17-bit sum, bit 16 is the carry out
module Adder (
  input  logic [15:0] OperandoA,
  input  logic [15:0] OperandoB,
  output logic [16:0] Soma
);

  assign Soma = {1'b0, OperandoA} + {1'b0, OperandoB};

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier (LARGURA x LARGURA -> 2*LARGURA).
// One add/shift step per clock for LARGURA clocks, then the product is
// registered and announced with a one-cycle Pronto strobe.
// Ports:
//   Clk    rising-edge clock
//   Reset  synchronous, active-high; aborts any operation in progress
//   bus    slave side of shift_add_multiplier_if (Start, operands, Produto,
//          Pronto, Ocupado)
module shift_add_multiplier
  import multiplicador_pkg::*;
#(
  parameter int unsigned LARGURA = LARGURA_PADRAO
) (
  input  logic                     Clk,
  input  logic                     Reset,
  shift_add_multiplier_if.slave    bus
);

  localparam int unsigned   LC     = largura_contador(LARGURA);
  localparam logic [LC-1:0] ULTIMO = LC'(LARGURA - 1);

  estado_t estado;
  estado_t estado_prox;

  logic [LARGURA-1:0]   m;
  logic [LARGURA-1:0]   a;
  logic [LARGURA-1:0]   q;
  logic [LC-1:0]        contador;
  logic [2*LARGURA-1:0] produto;

  logic [LARGURA-1:0]   operando_b;
  logic [LARGURA:0]     soma;
  logic                 c;
  logic [LARGURA-1:0]   a_prox;
  logic [LARGURA-1:0]   q_prox;
  logic                 ultimo_passo;
  logic                 pronto;
  logic                 ocupado;

  // ---------------------------------------------------------------------------
  // Adder: A + (Q[0] ? M : 0), full LARGURA+1-bit result
  // ---------------------------------------------------------------------------
  assign operando_b = q[0] ? m : '0;

  generate
    if (LARGURA == 16) begin : g_adder
      Adder u_adder (
        .OperandoA (a),
        .OperandoB (operando_b),
        .Soma      (soma)
      );
    end else begin : g_soma_inline
      assign soma = {1'b0, a} + {1'b0, operando_b};
    end
  endgenerate

  // {C,A,Q} >> 1: the carry becomes the new MSB of A and the sum's LSB
  // moves into the top of Q, so the carry is never lost.
  assign c      = soma[LARGURA];
  assign a_prox = {c, soma[LARGURA-1:1]};
  assign q_prox = {soma[0], q[LARGURA-1:1]};

  assign ultimo_passo = (contador == ULTIMO);

  // ---------------------------------------------------------------------------
  // Controller: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Reset) begin
      estado <= IDLE;
    end else begin
      estado <= estado_prox;
    end
  end

  // ---------------------------------------------------------------------------
  // Controller: next state and state-decoded outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    estado_prox = estado;
    pronto      = 1'b0;
    ocupado     = 1'b0;
    unique case (estado)
      IDLE: begin
        if (bus.Start) begin
          estado_prox = CALC;
        end
      end
      CALC: begin
        ocupado = 1'b1;
        if (ultimo_passo) begin
          estado_prox = DONE;
        end
      end
      DONE: begin
        ocupado     = 1'b1;
        pronto      = 1'b1;
        estado_prox = IDLE;
      end
      default: begin
        estado_prox = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Reset) begin
      m        <= '0;
      a        <= '0;
      q        <= '0;
      contador <= '0;
      produto  <= '0;
    end else begin
      unique case (estado)
        IDLE: begin
          if (bus.Start) begin
            m        <= bus.Multiplicando;
            q        <= bus.Multiplicador;
            a        <= '0;
            contador <= '0;
          end
        end
        CALC: begin
          a        <= a_prox;
          q        <= q_prox;
          contador <= contador + LC'(1);
          // Produto only changes here, so it holds across later Starts.
          if (ultimo_passo) begin
            produto <= {a_prox, q_prox};
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.Produto = produto;
  assign bus.Pronto  = pronto;
  assign bus.Ocupado = ocupado;

endmodule

// File: tb/tb_shift_add_multiplier.sv
module tb_shift_add_multiplier;

  logic clk;
  logic reset;

  shift_add_multiplier_if #(.LARGURA(16)) bus ();

  shift_add_multiplier #(.LARGURA(16)) dut (
    .Clk   (clk),
    .Reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic [15:0] m;
    logic [15:0] q;
    logic [31:0] p;
  } vec_t;

  vec_t tabela[12];

  task automatic check(input string nome, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nome, got, exp);
  endtask

  // Requires the DUT to be idle on entry; leaves it idle on exit.
  // lat counts edges after the accepting edge until Pronto is seen.
  task automatic run_op(input logic [15:0] m, input logic [15:0] q,
                        output logic [31:0] prod, output int lat,
                        output bit estavel, output bit ocup_ok, output bit fim_ok);
    logic [31:0] anterior;
    anterior          = bus.Produto;
    bus.Start         = 1'b1;
    bus.Multiplicando = m;
    bus.Multiplicador = q;
    @(posedge clk); #1;
    bus.Start         = 1'b0;
    bus.Multiplicando = ~m;
    bus.Multiplicador = ~q;
    ocup_ok = bus.Ocupado && !bus.Pronto;
    lat     = -1;
    estavel = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (bus.Pronto) begin
        lat = i;
        break;
      end
      if (bus.Produto !== anterior) estavel = 1'b0;
    end
    prod = bus.Produto;
    @(posedge clk); #1;
    fim_ok = !bus.Pronto && !bus.Ocupado && (bus.Produto === prod);
  endtask

  initial begin
    logic [31:0] prod;
    int          lat;
    bit          estavel, ocup_ok, fim_ok;
    int          pulsos;
    logic [15:0] rm, rq;

    tabela[0]  = '{16'h0003, 16'h0005, 32'h0000000F};
    tabela[1]  = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001};
    tabela[2]  = '{16'h1234, 16'h0000, 32'h00000000};
    tabela[3]  = '{16'h0000, 16'hFFFF, 32'h00000000};
    tabela[4]  = '{16'h0001, 16'hFFFF, 32'h0000FFFF};
    tabela[5]  = '{16'hFFFF, 16'h0001, 32'h0000FFFF};
    tabela[6]  = '{16'h8000, 16'h8000, 32'h40000000};
    tabela[7]  = '{16'hFFFF, 16'h8000, 32'h7FFF8000};
    tabela[8]  = '{16'h00FF, 16'h0101, 32'h0000FFFF};
    tabela[9]  = '{16'hABCD, 16'h0010, 32'h000ABCD0};
    tabela[10] = '{16'h0007, 16'h0009, 32'h0000003F};
    tabela[11] = '{16'h1234, 16'h5678, 32'h06260060};

    reset             = 1'b1;
    bus.Start         = 1'b0;
    bus.Multiplicando = '0;
    bus.Multiplicador = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset_produto", bus.Produto, 0);
    check("reset_pronto", bus.Pronto, 0);
    check("reset_ocupado", bus.Ocupado, 0);

    // Directed vectors
    foreach (tabela[i]) begin
      run_op(tabela[i].m, tabela[i].q, prod, lat, estavel, ocup_ok, fim_ok);
      check($sformatf("vec%0d_produto", i), prod, tabela[i].p);
      check($sformatf("vec%0d_latencia", i), lat, 16);
      check($sformatf("vec%0d_ocupado", i), ocup_ok, 1);
      check($sformatf("vec%0d_fim", i), fim_ok, 1);
      check($sformatf("vec%0d_estavel", i), estavel, 1);
    end

    // Start held high; operands change mid-CALC
    bus.Start         = 1'b1;
    bus.Multiplicando = 16'h0003;
    bus.Multiplicador = 16'h0005;
    @(posedge clk); #1;
    bus.Multiplicando = 16'hFFFF;
    bus.Multiplicador = 16'hFFFF;
    check("hold_ocupado", bus.Ocupado, 1);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (bus.Pronto) begin
        lat = i;
        break;
      end
    end
    check("hold_latencia", lat, 16);
    check("hold_produto", bus.Produto, 32'h0000000F);
    @(posedge clk); #1;
    check("hold_idle_ocupado", bus.Ocupado, 0);
    check("hold_idle_pronto", bus.Pronto, 0);
    @(posedge clk); #1;
    bus.Start = 1'b0;
    check("hold_reaceite", bus.Ocupado, 1);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (bus.Pronto) begin
        lat = i;
        break;
      end
    end
    check("hold2_latencia", lat, 16);
    check("hold2_produto", bus.Produto, 32'hFFFE0001);
    @(posedge clk); #1;

    // Reset in the middle of CALC
    bus.Start         = 1'b1;
    bus.Multiplicando = 16'h00FF;
    bus.Multiplicador = 16'h0101;
    @(posedge clk); #1;
    bus.Start = 1'b0;
    check("rst_meio_ocupado", bus.Ocupado, 1);
    repeat (8) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst_meio_ocupado0", bus.Ocupado, 0);
    check("rst_meio_pronto0", bus.Pronto, 0);
    check("rst_meio_produto0", bus.Produto, 0);
    pulsos = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (bus.Pronto || bus.Ocupado) pulsos++;
    end
    check("rst_meio_sem_pronto", pulsos, 0);
    check("rst_meio_produto_fixo", bus.Produto, 0);
    run_op(16'd7, 16'd9, prod, lat, estavel, ocup_ok, fim_ok);
    check("pos_rst_produto", prod, 32'h0000003F);
    check("pos_rst_latencia", lat, 16);

    // Random back-to-back operations
    for (int n = 0; n < 200; n++) begin
      rm = 16'($urandom % 65536);
      rq = 16'($urandom % 65536);
      run_op(rm, rq, prod, lat, estavel, ocup_ok, fim_ok);
      check($sformatf("rnd%0d_produto %0h*%0h", n, rm, rq), prod, 32'(rm) * 32'(rq));
      check($sformatf("rnd%0d_latencia", n), lat, 16);
      check($sformatf("rnd%0d_estavel", n), estavel, 1);
      check($sformatf("rnd%0d_fim", n), fim_ok, 1);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
